// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with a small in-order buffer.
//
// Issues word-aligned fetch requests over a request/grant bus whose responses
// return in order with variable latency. Returned words are stored with their
// PCs in a DEPTH-entry FIFO. The head entry is presented to the core. A
// redirect empties the FIFO, restarts fetch at the new PC and discards every
// response still in flight.
//
// Optional build macro: FETCHQ_BYPASS_EN. When defined, a response arriving
// while the FIFO is empty (and nothing is being discarded) is forwarded
// combinationally to Instr/PC_out/InstrValid in the same cycle.
//
// Ports
//   CLK, RST          clock (rising edge), asynchronous active-low reset
//   Redirect          core writes the PC this cycle
//   RedirectPC[31:0]  new fetch address, bits [1:0] ignored
//   Advance           core consumes the head instruction this cycle
//   IMemReq/IMemAddr  fetch request valid / word-aligned address
//   IMemGnt           request accepted this cycle
//   IMemRvalid/Rdata  in-order response valid / instruction word
//   Instr/PC_out      head instruction and its address (0 when not valid)
//   InstrValid        head entry valid
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Advance,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRvalid,
  input  logic [31:0] IMemRdata,
  output logic [31:0] Instr,
  output logic [31:0] PC_out,
  output logic        InstrValid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] squash_q, squash_d;

  logic [CW:0] inflight;
  logic        grant, rvalid_ok, squash_hit, head_valid;
  logic        bypass, bypass_take, push, pop_head;
  logic        unused_pc_lsbs;

  assign unused_pc_lsbs = ^RedirectPC[1:0];

  // Requests are only issued while a FIFO slot is reserved for every response.
  assign inflight   = {1'b0, outst_q} + {1'b0, count_q};
  assign IMemReq    = RST && (inflight < DEPTH_L);
  assign IMemAddr   = fetch_pc_q;
  assign grant      = IMemReq && IMemGnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rvalid_ok  = IMemRvalid && (outst_q != '0);
  assign squash_hit = rvalid_ok && (squash_q != '0);
  assign head_valid = (count_q != '0);

`ifdef FETCHQ_BYPASS_EN
  assign bypass = rvalid_ok && !squash_hit && !head_valid && !Redirect;
`else
  assign bypass = 1'b0;
`endif

  assign bypass_take = bypass && Advance;
  assign pop_head    = !Redirect && Advance && head_valid;
  assign push        = rvalid_ok && !squash_hit && !Redirect && !bypass_take;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    squash_d   = squash_q;
    outst_d    = outst_q + CW'(grant) - CW'(rvalid_ok);

    if (Redirect) begin
      fetch_pc_d = {RedirectPC[31:2], 2'b00};
      resp_pc_d  = {RedirectPC[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // Everything still in flight after this cycle, including a request
      // granted right now, belongs to the old stream and must be dropped.
      squash_d   = outst_d;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (squash_hit) squash_d = squash_q - CW'(1'b1);
      else if (rvalid_ok) resp_pc_d = resp_pc_q + 32'd4;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1'b1);
      if (pop_head) rd_ptr_d = rd_ptr_q + AW'(1'b1);
      count_d = count_q + CW'(push) - CW'(pop_head);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fetch_pc_q <= '0;
      resp_pc_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      squash_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      squash_q   <= squash_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge CLK) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= IMemRdata;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  always_comb begin
    InstrValid = 1'b0;
    Instr      = '0;
    PC_out     = '0;
    if (head_valid) begin
      InstrValid = 1'b1;
      Instr      = instr_mem_q[rd_ptr_q];
      PC_out     = pc_mem_q[rd_ptr_q];
    end else if (bypass) begin
      InstrValid = 1'b1;
      Instr      = IMemRdata;
      PC_out     = resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        CLK;
  logic        RST;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Advance;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemRvalid;
  logic [31:0] IMemRdata;
  logic [31:0] Instr;
  logic [31:0] PC_out;
  logic        InstrValid;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .Advance(Advance), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemGnt(IMemGnt), .IMemRvalid(IMemRvalid), .IMemRdata(IMemRdata),
    .Instr(Instr), .PC_out(PC_out), .InstrValid(InstrValid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: requests in flight (with a discard flag) and buffered words.
  typedef struct { logic [31:0] addr; int due; bit stale; } inf_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  inf_t infl[$];
  ent_t fifo[$];
  logic [31:0] m_fetch;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int gnt_pct = 100;
  int lat_lo = 1;
  int lat_hi = 1;
  bit stray = 0;
  bit g_last;

  // {IMemReq, IMemAddr, InstrValid, Instr, PC_out}
  logic [97:0] obs_v, exp_v;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hE3A00001 + (a >> 2) * 32'h1001;
  endfunction

  function automatic bit o_req();   return obs_v[97]; endfunction
  function automatic logic [31:0] o_addr(); return obs_v[96:65]; endfunction
  function automatic bit o_valid(); return obs_v[64]; endfunction
  function automatic logic [31:0] o_pc();   return obs_v[31:0]; endfunction

  task automatic model_clear();
    infl.delete();
    fifo.delete();
    m_fetch = 32'h0;
    cyc = 1;
  endtask

  // One clock cycle: drive at the falling edge, sample 1ns later, advance the
  // model at the rising edge, return at the next falling edge.
  task automatic step(input bit adv, input bit redir, input logic [31:0] rpc);
    bit rv, gnt, byp, dg, e_req, had_head;
    logic [31:0] rd;
    inf_t h;
    ent_t tmp;
    h = '{32'h0, 0, 1'b0};
    gnt = ($urandom_range(99) < gnt_pct);
    rv = 1'b0;
    rd = $urandom;
    if (infl.size() > 0) begin
      if (infl[0].due <= cyc) begin
        rv = 1'b1;
        rd = word_of(infl[0].addr);
      end
    end else if (stray) begin
      rv = 1'b1;
    end
    IMemGnt = gnt; IMemRvalid = rv; IMemRdata = rd;
    Redirect = redir; RedirectPC = rpc; Advance = adv;
    #1;
    e_req = (infl.size() + fifo.size()) < DEPTH;
    byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    byp = rv && (infl.size() > 0) && !redir && (fifo.size() == 0);
    if (byp) byp = !infl[0].stale;
`endif
    exp_v = {e_req, m_fetch, 1'b0, 32'h0, 32'h0};
    if (fifo.size() > 0) exp_v[64:0] = {1'b1, fifo[0].instr, fifo[0].pc};
    else if (byp) exp_v[64:0] = {1'b1, rd, infl[0].addr};
    obs_v = {IMemReq, IMemAddr, InstrValid, Instr, PC_out};
    g_last = gnt;
    @(posedge CLK);
    dg = e_req && gnt;
    had_head = 1'b0;
    if (rv && infl.size() > 0) begin
      h = infl.pop_front();
      had_head = 1'b1;
    end
    if (redir) begin
      fifo.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      if (dg) infl.push_back('{m_fetch, cyc + $urandom_range(lat_hi, lat_lo), 1'b1});
      m_fetch = {rpc[31:2], 2'b00};
    end else begin
      if (adv && fifo.size() > 0) tmp = fifo.pop_front();
      if (had_head && !h.stale && !(byp && adv)) fifo.push_back('{rd, h.addr});
      if (dg) begin
        infl.push_back('{m_fetch, cyc + $urandom_range(lat_hi, lat_lo), 1'b0});
        m_fetch = m_fetch + 32'd4;
      end
    end
    cyc++;
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    RST = 1'b0; Redirect = 0; RedirectPC = 0; Advance = 0;
    IMemGnt = 0; IMemRvalid = 0; IMemRdata = 0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    model_clear();
    stray = 0;
  endtask

  task automatic test_reset();
    RST = 1'b0; Redirect = 0; RedirectPC = 0; Advance = 0;
    IMemGnt = 0; IMemRvalid = 0; IMemRdata = 0;
    @(negedge CLK);
    #1;
    obs_v = {IMemReq, IMemAddr, InstrValid, Instr, PC_out};
    n_chk++;
    if (obs_v !== 98'h0) begin
      n_fail++;
      $display("FAIL reset_idle got=%h expected=0", obs_v);
    end
    IMemGnt = 1; IMemRvalid = 1; IMemRdata = 32'h12345678; Advance = 1;
    @(negedge CLK);
    #1;
    obs_v = {IMemReq, IMemAddr, InstrValid, Instr, PC_out};
    n_chk++;
    if (obs_v !== 98'h0) begin
      n_fail++;
      $display("FAIL reset_busy_inputs got=%h expected=0", obs_v);
    end
    apply_reset();
  endtask

  task automatic test_stream();
    int first, c;
    apply_reset();
    gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      c = cyc;
      step(1'b1, 1'b0, 32'h0);
      if (o_valid() && first < 0) first = c;
      n_chk++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL stream cyc=%0d got=%h expected=%h", c, obs_v, exp_v);
      end
    end
    n_chk++;
`ifdef FETCHQ_BYPASS_EN
    if (first != 2) begin
      n_fail++;
      $display("FAIL stream_first_valid got=%0d expected=2", first);
    end
`else
    if (first != 3) begin
      n_fail++;
      $display("FAIL stream_first_valid got=%0d expected=3", first);
    end
`endif
  endtask

  task automatic test_full();
    int grants;
    apply_reset();
    gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (o_req() && g_last) grants++;
      n_chk++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL full_fill cyc=%0d got=%h expected=%h", cyc - 1, obs_v, exp_v);
      end
    end
    n_chk++;
    if (grants != DEPTH || !o_valid() || o_pc() !== 32'h0 || o_req()) begin
      n_fail++;
      $display("FAIL full_hold grants=%0d valid=%0d pc=%h req=%0d expected 4/1/0/0",
               grants, o_valid(), o_pc(), o_req());
    end
    step(1'b1, 1'b0, 32'h0);
    n_chk++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL full_pop got=%h expected=%h", obs_v, exp_v);
    end
    step(1'b0, 1'b0, 32'h0);
    n_chk++;
    if (!o_req() || o_addr() !== 32'h10 || obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL full_refill got=%h expected req=1 addr=00000010", obs_v);
    end
  endtask

  task automatic test_redirect_stale();
    logic [31:0] pcs[$];
    apply_reset();
    gnt_pct = 100; lat_lo = 4; lat_hi = 4;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0);
      n_chk++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL stale_issue got=%h expected=%h", obs_v, exp_v);
      end
    end
    gnt_pct = 0;
    step(1'b0, 1'b1, 32'h100);
    gnt_pct = 100;
    for (int i = 0; i < 40 && pcs.size() < 2; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (o_valid()) pcs.push_back(o_pc());
      n_chk++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL stale_drain got=%h expected=%h", obs_v, exp_v);
      end
    end
    n_chk++;
    if (pcs.size() < 2) begin
      n_fail++;
      $display("FAIL stale_timeout got=%0d valid words expected=2", pcs.size());
    end else if (pcs[0] !== 32'h100 || pcs[1] !== 32'h104) begin
      n_fail++;
      $display("FAIL stale_pcs got=%h,%h expected=00000100,00000104", pcs[0], pcs[1]);
    end
  endtask

  task automatic test_redirect_collide();
    apply_reset();
    gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h203);
    n_chk++;
    if (obs_v !== exp_v || IMemRvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_cycle got=%h expected=%h rvalid=%0d", obs_v, exp_v, IMemRvalid);
    end
    step(1'b0, 1'b0, 32'h0);
    n_chk++;
    if (o_valid() || o_addr() !== 32'h200 || !o_req() || obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL collide_after got=%h expected valid=0 req=1 addr=00000200", obs_v);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[$];
    apply_reset();
    gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (o_req() && g_last) addrs.push_back(o_addr());
      n_chk++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL wrap_step got=%h expected=%h", obs_v, exp_v);
      end
    end
    n_chk++;
    if (addrs.size() < 3) begin
      n_fail++;
      $display("FAIL wrap_count got=%0d expected>=3", addrs.size());
    end else if (addrs[0] !== 32'hFFFF_FFF8 || addrs[1] !== 32'hFFFF_FFFC || addrs[2] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_addrs got=%h,%h,%h expected=fffffff8,fffffffc,00000000",
               addrs[0], addrs[1], addrs[2]);
    end
  endtask

  task automatic test_random();
    bit adv, rd;
    apply_reset();
    gnt_pct = 70; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 600; i++) begin
      adv = ($urandom_range(3) != 0);
      rd  = ($urandom_range(39) == 0);
      step(adv, rd, $urandom);
      n_chk++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h expected=%h", cyc - 1, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    gnt_pct = 100; lat_lo = 3; lat_hi = 3;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    #2 RST = 1'b0;
    #1;
    obs_v = {IMemReq, IMemAddr, InstrValid, Instr, PC_out};
    n_chk++;
    if (obs_v !== 98'h0) begin
      n_fail++;
      $display("FAIL async_reset got=%h expected=0", obs_v);
    end
    IMemRvalid = 1'b1; IMemRdata = 32'hDEAD_BEEF;
    @(negedge CLK);
    RST = 1'b1;
    model_clear();
    stray = 1; gnt_pct = 0;
    step(1'b1, 1'b0, 32'h0);
    n_chk++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL async_stray got=%h expected=%h", obs_v, exp_v);
    end
    stray = 0; gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 32'h0);
      n_chk++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL async_restart got=%h expected=%h", obs_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_stale();
    test_redirect_collide();
    test_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
